// File: rtl/cabac_mv_pair_sched.sv
// Motion-vector context-pair sequencer: captures both lists of one PU,
// then streams the non-empty pairs to the BAE queue one per cycle.
module cabac_mv_pair_sched #(
   parameter int PAIR_W   = 11,
   parameter int PAIR_NUM = 15,
   parameter int MODE_LSB = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start_i,
   input  logic [1:0]                 inter_dir_i,
   input  logic [PAIR_NUM*PAIR_W-1:0] pair_mv_0_i,
   input  logic [PAIR_NUM*PAIR_W-1:0] pair_mv_1_i,
   output logic                       busy_o,
   output logic                       pair_valid_o,
   output logic [PAIR_W-1:0]          pair_o,
   output logic                       pair_last_o,
   input  logic                       pair_ready_i,
   output logic                       done_o,
   output logic [4:0]                 pair_cnt_o
);

   localparam int TOT = 2 * PAIR_NUM;
   localparam int IW  = 5;

   typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

   state_t            state, state_nx;
   logic [PAIR_W-1:0] pairs [TOT];
   logic [TOT-1:0]    mask, mask_new, above;
   logic [IW-1:0]     idx, idx_first, idx_next;
   logic [4:0]        cnt;
   logic              has_next, accept, send, hs;

   assign accept = start_i && (state == IDLE);
   assign send   = (state == SEND);
   assign hs     = send && pair_ready_i;

   // A pair counts only if its mode field is set and its list is enabled.
   always_comb begin
      mask_new = '0;
      for (int k = 0; k < PAIR_NUM; k++) begin
         mask_new[k] = inter_dir_i[0] &&
            (pair_mv_0_i[k*PAIR_W+MODE_LSB +: 3] != 3'd0);
         mask_new[PAIR_NUM+k] = inter_dir_i[1] &&
            (pair_mv_1_i[k*PAIR_W+MODE_LSB +: 3] != 3'd0);
      end
   end

   always_comb begin
      idx_first = '0;
      for (int i = TOT - 1; i >= 0; i--)
         if (mask_new[i]) idx_first = IW'(i);
   end

   always_comb begin
      above    = '0;
      idx_next = '0;
      for (int i = 0; i < TOT; i++)
         above[i] = mask[i] && (i > int'(idx));
      for (int i = TOT - 1; i >= 0; i--)
         if (above[i]) idx_next = IW'(i);
      has_next = |above;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TOT; i++) pairs[i] <= '0;
         mask <= '0;
         idx  <= '0;
         cnt  <= '0;
      end else if (accept) begin
         for (int k = 0; k < PAIR_NUM; k++) begin
            pairs[k]          <= pair_mv_0_i[k*PAIR_W +: PAIR_W];
            pairs[PAIR_NUM+k] <= pair_mv_1_i[k*PAIR_W +: PAIR_W];
         end
         mask <= mask_new;
         idx  <= idx_first;
         cnt  <= '0;
      end else if (hs) begin
         cnt <= cnt + 5'd1;
         if (has_next) idx <= idx_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = (|mask_new) ? SEND : FIN;
         SEND: if (hs && !has_next) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy_o       = (state != IDLE);
      pair_valid_o = send;
      pair_o       = send ? pairs[idx] : '0;
      pair_last_o  = send && !has_next;
      done_o       = (state == FIN);
      pair_cnt_o   = cnt;
   end

endmodule
